// File: rtl/ed_channel_scheduler.sv
// Sequences the R, G and B planes of one 3x3 window through a single shared edge detector (5+ED_LATENCY cycles per window).
// One window in flight at a time; results are held on out_valid for as long as out_ready stays low.
module ed_channel_scheduler #(
    parameter int ED_LATENCY = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_pixel_1,
    input  logic [23:0] in_pixel_2,
    input  logic [23:0] in_pixel_3,
    input  logic [23:0] in_pixel_4,
    input  logic [23:0] in_pixel_6,
    input  logic [23:0] in_pixel_7,
    input  logic [23:0] in_pixel_8,
    input  logic [23:0] in_pixel_9,
    output logic [7:0]  ed_pixel_1,
    output logic [7:0]  ed_pixel_2,
    output logic [7:0]  ed_pixel_3,
    output logic [7:0]  ed_pixel_4,
    output logic [7:0]  ed_pixel_6,
    output logic [7:0]  ed_pixel_7,
    output logic [7:0]  ed_pixel_8,
    output logic [7:0]  ed_pixel_9,
    output logic [1:0]  ed_ch_sel,
    output logic        ed_in_valid,
    input  logic [1:0]  ed_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  ED1_out,
    output logic [1:0]  ED2_out,
    output logic [1:0]  ED3_out,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [1:0] LAST_DRAIN = (ED_LATENCY > 0) ? 2'(ED_LATENCY - 1) : 2'd0;

    if (ED_LATENCY < 0 || ED_LATENCY > 2) begin : g_bad_latency
        $error("ed_channel_scheduler: ED_LATENCY must be 0, 1 or 2");
    end

    state_t      r_state;
    logic [1:0]  r_ch;
    logic [1:0]  r_dcnt;
    logic [23:0] r_px [8];
    logic [1:0]  r_ed1, r_ed2, r_ed3;

    logic        w_issue;
    logic [2:0]  w_tag_in;
    logic [2:0]  w_tag;

    assign w_issue  = (r_state == ISSUE);
    assign w_tag_in = {w_issue, r_ch};

    // Tag {valid, ch} follows each issue through the detector so the result lands in the right plane.
    if (ED_LATENCY == 0) begin : g_no_pipe
        assign w_tag = w_tag_in;
    end else begin : g_pipe
        logic [2:0] r_tag [ED_LATENCY];
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int i = 0; i < ED_LATENCY; i++) r_tag[i] <= '0;
            end else begin
                r_tag[0] <= w_tag_in;
                for (int i = 1; i < ED_LATENCY; i++) r_tag[i] <= r_tag[i-1];
            end
        end
        assign w_tag = r_tag[ED_LATENCY-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ch    <= 2'd0;
            r_dcnt  <= 2'd0;
            for (int i = 0; i < 8; i++) r_px[i] <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_px[0] <= in_pixel_1;
                        r_px[1] <= in_pixel_2;
                        r_px[2] <= in_pixel_3;
                        r_px[3] <= in_pixel_4;
                        r_px[4] <= in_pixel_6;
                        r_px[5] <= in_pixel_7;
                        r_px[6] <= in_pixel_8;
                        r_px[7] <= in_pixel_9;
                        r_ch    <= 2'd0;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (r_ch == 2'd2) begin
                        r_ch    <= 2'd0;
                        r_dcnt  <= 2'd0;
                        r_state <= (ED_LATENCY > 0) ? DRAIN : DONE;
                    end else begin
                        r_ch <= r_ch + 2'd1;
                    end
                end
                DRAIN: begin
                    if (r_dcnt == LAST_DRAIN) r_state <= DONE;
                    else                      r_dcnt  <= r_dcnt + 2'd1;
                end
                DONE: begin
                    if (out_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ed1 <= 2'd0;
            r_ed2 <= 2'd0;
            r_ed3 <= 2'd0;
        end else if (w_tag[2]) begin
            case (w_tag[1:0])
                2'd0:    r_ed1 <= ed_result;
                2'd1:    r_ed2 <= ed_result;
                2'd2:    r_ed3 <= ed_result;
                default: ;
            endcase
        end
    end

    function automatic logic [7:0] f_slice(input logic [23:0] px, input logic [1:0] ch);
        case (ch)
            2'd0:    return px[23:16];
            2'd1:    return px[15:8];
            default: return px[7:0];
        endcase
    endfunction

    assign ed_pixel_1 = w_issue ? f_slice(r_px[0], r_ch) : 8'd0;
    assign ed_pixel_2 = w_issue ? f_slice(r_px[1], r_ch) : 8'd0;
    assign ed_pixel_3 = w_issue ? f_slice(r_px[2], r_ch) : 8'd0;
    assign ed_pixel_4 = w_issue ? f_slice(r_px[3], r_ch) : 8'd0;
    assign ed_pixel_6 = w_issue ? f_slice(r_px[4], r_ch) : 8'd0;
    assign ed_pixel_7 = w_issue ? f_slice(r_px[5], r_ch) : 8'd0;
    assign ed_pixel_8 = w_issue ? f_slice(r_px[6], r_ch) : 8'd0;
    assign ed_pixel_9 = w_issue ? f_slice(r_px[7], r_ch) : 8'd0;

    assign ed_in_valid = w_issue;
    assign ed_ch_sel   = w_issue ? r_ch : 2'd0;
    assign in_ready    = rst_n && (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign busy        = (r_state != IDLE);
    assign ED1_out     = r_ed1;
    assign ED2_out     = r_ed2;
    assign ED3_out     = r_ed3;

endmodule

// File: tb/tb_ed_channel_scheduler.sv
// Bench for ed_channel_scheduler: three instances (ED_LATENCY 0, 1, 2), each driving its own stub detector.
module tb_ed_channel_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic [7:0][23:0]     win;
    logic [2:0]           in_vld, in_rdy, edv, ov, ordy, bsy;
    logic [2:0][1:0]      chsel, edr, ed1, ed2, ed3;
    logic [2:0][7:0][7:0] edp;
    int                   stub_mode [3];
    int                   n_cmp = 0;
    int                   n_err = 0;
    int                   cyc = 0;

    // Stub detector code: mode 0 -> ch+1, mode 1 -> {3,0,1}, mode 2 -> hash of the 8 neighbour bytes.
    function automatic logic [1:0] stub_code(input logic [7:0][7:0] b, input logic [1:0] ch, input int mode);
        int s;
        s = 0;
        case (mode)
            0: return ch + 2'd1;
            1: begin
                case (ch)
                    2'd0:    return 2'd3;
                    2'd1:    return 2'd0;
                    default: return 2'd1;
                endcase
            end
            default: begin
                for (int k = 0; k < 8; k++) s += int'(b[k]);
                return s[1:0] ^ s[3:2] ^ ch;
            end
        endcase
    endfunction

    function automatic logic [7:0][7:0] slice(input logic [7:0][23:0] px, input int c);
        logic [7:0][7:0] r;
        for (int k = 0; k < 8; k++) r[k] = px[k][8*(2-c) +: 8];
        return r;
    endfunction

    function automatic logic [7:0][23:0] rand_win();
        logic [7:0][23:0] w;
        for (int k = 0; k < 8; k++) w[k] = 24'($urandom);
        return w;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [1:0] code_now;
        logic [1:0] junk = 2'd0;
        logic [1:0] dl0 = 2'd0, dl1 = 2'd0;
        logic       dv0 = 1'b0, dv1 = 1'b0;
        int         hs = 0;

        always_comb code_now = stub_code(edp[g], chsel[g], stub_mode[g]);

        always @(posedge clk) begin
            dl0  <= code_now;
            dv0  <= edv[g];
            dl1  <= dl0;
            dv1  <= dv0;
            junk <= 2'($urandom);
            if (ov[g] && ordy[g]) hs <= hs + 1;
        end

        if (g == 0) begin : g_l0
            assign edr[g] = edv[g] ? code_now : junk;
        end else if (g == 1) begin : g_l1
            assign edr[g] = dv0 ? dl0 : junk;
        end else begin : g_l2
            assign edr[g] = dv1 ? dl1 : junk;
        end

        ed_channel_scheduler #(.ED_LATENCY(g)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (in_vld[g]),
            .in_ready   (in_rdy[g]),
            .in_pixel_1 (win[0]),
            .in_pixel_2 (win[1]),
            .in_pixel_3 (win[2]),
            .in_pixel_4 (win[3]),
            .in_pixel_6 (win[4]),
            .in_pixel_7 (win[5]),
            .in_pixel_8 (win[6]),
            .in_pixel_9 (win[7]),
            .ed_pixel_1 (edp[g][0]),
            .ed_pixel_2 (edp[g][1]),
            .ed_pixel_3 (edp[g][2]),
            .ed_pixel_4 (edp[g][3]),
            .ed_pixel_6 (edp[g][4]),
            .ed_pixel_7 (edp[g][5]),
            .ed_pixel_8 (edp[g][6]),
            .ed_pixel_9 (edp[g][7]),
            .ed_ch_sel  (chsel[g]),
            .ed_in_valid(edv[g]),
            .ed_result  (edr[g]),
            .out_valid  (ov[g]),
            .out_ready  (ordy[g]),
            .ED1_out    (ed1[g]),
            .ED2_out    (ed2[g]),
            .ED3_out    (ed3[g]),
            .busy       (bsy[g])
        );
    end

    function automatic int hs_of(input int g);
        case (g)
            0:       return g_dut[0].hs;
            1:       return g_dut[1].hs;
            default: return g_dut[2].hs;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [5:0] model(input logic [7:0][23:0] px, input int mode);
        logic [5:0] r;
        for (int c = 0; c < 3; c++) r[4-2*c +: 2] = stub_code(slice(px, c), 2'(c), mode);
        return r;
    endfunction

    // One full window on instance g, checked cycle by cycle; ov_cyc is the cycle out_valid first shows.
    task automatic run_win(input int g, input logic [7:0][23:0] px, input logic [5:0] codes,
                           input int bp, input bit hold, output int ov_cyc);
        int k;
        for (int j = 0; j < 3; j++) if (j != g) in_vld[j] = 1'b0;
        k = 0;
        while (!in_rdy[g] && k < 30) begin
            tick();
            k++;
        end
        chk("in_ready before accept", 64'(in_rdy[g]), 64'd1);
        win       = px;
        in_vld[g] = 1'b1;
        ordy[g]   = (bp == 0);
        tick();
        in_vld[g] = hold;
        win       = rand_win();
        for (int c = 0; c < 3; c++) begin
            chk("issue ctl", {edv[g], chsel[g], in_rdy[g], ov[g]}, {1'b1, 2'(c), 1'b0, 1'b0});
            chk("issue pixels", edp[g], slice(px, c));
            tick();
        end
        for (int d = 0; d < g; d++) begin
            chk("drain ctl", {edv[g], ov[g], bsy[g], in_rdy[g]}, 4'b0010);
            tick();
        end
        ov_cyc = cyc;
        chk("done ctl", {ov[g], edv[g], bsy[g], in_rdy[g]}, 4'b1010);
        chk("codes", {ed1[g], ed2[g], ed3[g]}, codes);
        chk("idle pixels", edp[g], 64'd0);
        for (int b = 0; b < bp; b++) begin
            tick();
            win = rand_win();
            chk("backpressure hold", {ov[g], in_rdy[g], ed1[g], ed2[g], ed3[g]}, {2'b10, codes});
        end
        ordy[g] = 1'b1;
        tick();
        chk("after handshake", {ov[g], bsy[g], in_rdy[g], ed1[g], ed2[g], ed3[g]}, {3'b001, codes});
    endtask

    typedef struct {
        int               lat;
        logic [7:0][23:0] px;
        int               mode;
        int               bp;
        logic [5:0]       codes;
    } vec_t;

    vec_t vt [6];

    initial begin : timeout
        #200000;
        $display("FAIL timeout: bench did not reach summary, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int               oc, prev, hs0;
        logic [7:0][23:0] px;
        logic [5:0]       e;

        for (int k = 0; k < 8; k++) vt[0].px[k] = {8'(8'h10 + k), 8'(8'h40 + k), 8'(8'h80 + k)};
        vt[0].lat = 0; vt[0].mode = 0; vt[0].bp = 0; vt[0].codes = {2'd1, 2'd2, 2'd3};
        vt[1].px = {8{24'h123456}}; vt[1].px[0] = 24'hFF8000;
        vt[1].lat = 2; vt[1].mode = 1; vt[1].bp = 0; vt[1].codes = {2'd3, 2'd0, 2'd1};
        vt[2].px = rand_win();
        vt[2].lat = 1; vt[2].mode = 1; vt[2].bp = 2; vt[2].codes = {2'd3, 2'd0, 2'd1};
        vt[3].px = {8{24'hFFFFFF}};
        vt[3].lat = 0; vt[3].mode = 2; vt[3].bp = 0; vt[3].codes = {2'd2, 2'd3, 2'd0};
        vt[4].px = '0;
        vt[4].lat = 2; vt[4].mode = 2; vt[4].bp = 1; vt[4].codes = {2'd0, 2'd1, 2'd2};
        vt[5].px = rand_win();
        vt[5].lat = 1; vt[5].mode = 0; vt[5].bp = 1; vt[5].codes = {2'd1, 2'd2, 2'd3};

        rst_n = 1'b0; in_vld = '0; ordy = '0; win = '0;
        stub_mode = '{0, 0, 0};
        repeat (3) tick();
        for (int g = 0; g < 3; g++) begin
            chk("reset outputs", {in_rdy[g], ov[g], edv[g], bsy[g], chsel[g], ed1[g], ed2[g], ed3[g]}, 64'd0);
            chk("reset pixels", edp[g], 64'd0);
        end
        rst_n = 1'b1;
        tick();
        chk("in_ready after reset", 64'(in_rdy), 64'd7);

        for (int i = 0; i < 6; i++) begin
            stub_mode[vt[i].lat] = vt[i].mode;
            run_win(vt[i].lat, vt[i].px, vt[i].codes, vt[i].bp, 1'b0, oc);
        end

        // Long backpressure with in_valid held and pixels churning; next window lands one cycle after release.
        stub_mode[0] = 0;
        run_win(0, rand_win(), {2'd1, 2'd2, 2'd3}, 10, 1'b1, oc);
        run_win(0, rand_win(), {2'd1, 2'd2, 2'd3}, 0, 1'b0, oc);

        // Back-to-back stream at ED_LATENCY=1: one result every 6 cycles.
        stub_mode[1] = 2;
        hs0 = hs_of(1);
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            px = rand_win();
            run_win(1, px, model(px, 2), 0, 1'b1, oc);
            if (i > 0) chk("stream spacing", 64'(oc - prev), 64'd6);
            prev = oc;
        end
        in_vld[1] = 1'b0;
        chk("stream handshakes", 64'(hs_of(1) - hs0), 64'd4);

        // Reset during the ch=1 issue cycle at ED_LATENCY=2: in-flight codes must be dropped.
        stub_mode[2] = 2;
        hs0 = hs_of(2);
        in_vld = '0;
        win = rand_win();
        in_vld[2] = 1'b1;
        tick();
        in_vld[2] = 1'b0;
        tick();
        chk("abort at ch1", {edv[2], chsel[2]}, 3'b101);
        rst_n = 1'b0;
        chk("in_ready in reset", 64'(in_rdy[2]), 64'd0);
        tick();
        rst_n = 1'b1;
        chk("abort outputs", {ov[2], edv[2], bsy[2], chsel[2], ed1[2], ed2[2], ed3[2]}, 64'd0);
        chk("abort pixels", edp[2], 64'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("abort quiet", {ov[2], bsy[2], ed1[2], ed2[2], ed3[2]}, 64'd0);
        end
        px = rand_win();
        run_win(2, px, model(px, 2), 0, 1'b0, oc);
        chk("abort handshakes", 64'(hs_of(2) - hs0), 64'd1);

        for (int i = 0; i < 30; i++) begin
            int g;
            g = $urandom_range(2);
            stub_mode[g] = 2;
            in_vld = '0;
            repeat ($urandom_range(2)) tick();
            px = rand_win();
            e  = model(px, 2);
            run_win(g, px, e, $urandom_range(3), 1'($urandom_range(1)), oc);
        end
        in_vld = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ed_channel_scheduler.md
Name: ed_channel_scheduler

Overview:
- Time-shares one single-channel edge-detection unit (8-neighbour, 8-bit, 2-bit edge code) across the R, G and B planes of one 3x3 RGB window.
- Sits between the 3x3 window generator and the transmission-estimation logic.
- Replaces three parallel channel detectors with one detector plus this sequencer.
- Valid/ready on the window input and on the result output.

Parameters:
- ED_LATENCY, 0: clock cycles from ed_in_valid/ed_pixel_* to matching ed_result. Legal values 0, 1, 2. 0 means the shared unit is combinational.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  window valid.
- in_ready  output  1  block can accept a window.
- in_pixel_1, in_pixel_2, in_pixel_3, in_pixel_4, in_pixel_6, in_pixel_7, in_pixel_8, in_pixel_9  input  24 each  neighbour pixels, {R[23:16], G[15:8], B[7:0]}. Centre pixel 5 is not used.
- ed_pixel_1, ed_pixel_2, ed_pixel_3, ed_pixel_4, ed_pixel_6, ed_pixel_7, ed_pixel_8, ed_pixel_9  output  8 each  selected channel slice to the shared detector.
- ed_ch_sel  output  2  channel being issued: 0=R, 1=G, 2=B.
- ed_in_valid  output  1  issue strobe to the shared detector.
- ed_result  input  2  edge code from the shared detector.
- out_valid  output  1  results valid.
- out_ready  input  1  downstream accepts results.
- ED1_out, ED2_out, ED3_out  output  2 each  edge codes for R, G, B.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, ISSUE, DRAIN, DONE.
- Reset:
  - While rst_n is low at a rising edge: state<=IDLE, channel counter<=0.
  - Window register, result registers and tag pipeline cleared.
  - ED1_out, ED2_out, ED3_out = 0; out_valid = 0; ed_in_valid = 0; ed_ch_sel = 0; busy = 0.
  - in_ready is forced 0 while rst_n is low.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready at edge t: latch all eight 24-bit pixels and go to ISSUE with ch=0.
  - Input pixels are ignored at all other times; changes after acceptance have no effect.
- ISSUE (cycles t+1, t+2, t+3):
  - ed_in_valid = 1 and ed_ch_sel = ch.
  - ed_pixel_k = latched pixel_k slice: R [23:16] for ch=0, G [15:8] for ch=1, B [7:0] for ch=2.
  - ch increments each cycle. After ch=2, go to DRAIN if ED_LATENCY > 0, otherwise to DONE.
  - Outside ISSUE: ed_in_valid = 0, ed_ch_sel = 0, all ed_pixel_* = 0.
- Capture:
  - A tag pipeline of depth ED_LATENCY carries {valid, ch}.
  - ed_result is sampled at the edge ending the cycle in which the delayed tag is valid: ch 0 -> ED1, ch 1 -> ED2, ch 2 -> ED3.
  - With ED_LATENCY=0, sampling happens in the issue cycle itself.
  - Codes are stored unmodified. Result registers change only on capture.
- DRAIN:
  - Lasts exactly ED_LATENCY cycles (t+4 .. t+3+ED_LATENCY), then go to DONE.
- DONE:
  - out_valid = 1 from cycle t+4+ED_LATENCY.
  - ED*_out hold stable while out_valid && !out_ready.
  - On out_valid && out_ready, go to IDLE; out_valid drops next cycle. ED*_out keep their last values.
- Handshake:
  - in_ready is 0 in ISSUE, DRAIN and DONE. No overlap of windows.
  - Minimum period is 5+ED_LATENCY cycles per window.
  - out_ready held high is never required; backpressure can last indefinitely.
- Simultaneous events: in DONE, in_valid high with out_ready high does not accept a window in the same cycle. Acceptance happens one cycle later in IDLE.
- Reset mid-operation: rst_n low in any state aborts the window. Results still in flight in the shared unit are discarded because the tag pipeline is cleared. No out_valid is produced for the aborted window.
- ed_result is ignored whenever the delayed tag is not valid.
- Illegal ED_LATENCY (>2) is a synthesis-time error via a generate-time check.

Test Plan:
1. ED_LATENCY=0. Stub detector returns code = ch+1.
   - One window, out_ready=1.
   - Expect: ED_pixel slices equal R, G, B in cycles t+1..t+3; ED1/ED2/ED3 = 1/2/3; out_valid exactly at t+4 for 1 cycle; in_ready high again at t+5.
2. ED_LATENCY=2, stub delays by 2 cycles with codes 3, 0, 1 (pixel_1 = 0xFF8000).
   - Expect: ed_pixel_1 = 0xFF, 0x80, 0x00 across the issue cycles; out_valid at t+6; ED1=3, ED2=0, ED3=1.
3. Backpressure: out_ready=0 for 10 cycles after out_valid, in_valid held high, input pixels changed.
   - Expect: in_ready=0 and ED*_out stable throughout.
   - Accept at the out_ready edge; the next window is accepted one cycle later.
4. Back-to-back stream of 4 windows, in_valid and out_ready always high, ED_LATENCY=1.
   - Expect: exactly 4 result handshakes, 6-cycle spacing, results in order.
5. rst_n low for 1 cycle during ISSUE at ch=1, with ED_LATENCY=2.
   - Expect: no out_valid afterwards, all outputs 0.
   - Late ed_result values are ignored.
   - The next window completes normally with correct codes.
